// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I datapath: operand forwarding,
// load-use bubbles, taken-branch flushes and cache-miss stalls with response latching.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ifid_rs1,
   input  logic [4:0]       ifid_rs2,
   input  logic [4:0]       idex_rs1,
   input  logic [4:0]       idex_rs2,
   input  logic [4:0]       idex_rd,
   input  logic             idex_load_regfile,
   input  logic             idex_dcache_read,
   input  logic [4:0]       exmem_rd,
   input  logic             exmem_load_regfile,
   input  logic             exmem_dcache_read,
   input  logic             exmem_dcache_write,
   input  logic [4:0]       memwb_rd,
   input  logic             memwb_load_regfile,
   input  logic             br_taken,
   input  logic             icache_resp,
   input  logic             dcache_resp,
   input  logic             stall_clr,
   output logic [1:0]       rs1mux_sel,
   output logic [1:0]       rs2mux_sel,
   output logic             pc_load,
   output logic             pipe_load_ifid,
   output logic             pipe_load_idex,
   output logic             pipe_load_exmem,
   output logic             pipe_load_memwb,
   output logic             pipe_rst_ifid,
   output logic             pipe_rst_idex,
   output logic             pipe_rst_exmem,
   output logic             pipe_rst_memwb,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic {S_RUN, S_WAIT} state_t;

   state_t state, state_nxt;
   logic   i_got, i_got_nxt;
   logic   d_got, d_got_nxt;
   logic   dreq, advance, lu;

   // A load result in EX/MEM is not available yet, so it is never forwarded from there.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (exmem_load_regfile && !exmem_dcache_read && exmem_rd != 5'd0 && exmem_rd == rs)
         return 2'd1;
      else if (memwb_load_regfile && memwb_rd != 5'd0 && memwb_rd == rs)
         return 2'd2;
      else
         return 2'd0;
   endfunction

   assign dreq    = exmem_dcache_read | exmem_dcache_write;
   assign advance = (icache_resp | i_got) & (~dreq | dcache_resp | d_got);
   assign lu      = idex_dcache_read & idex_load_regfile & (idex_rd != 5'd0) &
                    ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_RUN;
         i_got <= 1'b0;
         d_got <= 1'b0;
      end else begin
         state <= state_nxt;
         i_got <= i_got_nxt;
         d_got <= d_got_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      i_got_nxt = i_got;
      d_got_nxt = d_got;
      if (advance) begin
         state_nxt = S_RUN;
         i_got_nxt = 1'b0;
         d_got_nxt = 1'b0;
      end else begin
         state_nxt = S_WAIT;
         i_got_nxt = i_got | icache_resp;
         d_got_nxt = d_got | dcache_resp;
      end
   end

   always_comb begin
      rs1mux_sel      = 2'd0;
      rs2mux_sel      = 2'd0;
      pc_load         = 1'b0;
      pipe_load_ifid  = 1'b0;
      pipe_load_idex  = 1'b0;
      pipe_load_exmem = 1'b0;
      pipe_load_memwb = 1'b0;
      pipe_rst_ifid   = 1'b0;
      pipe_rst_idex   = 1'b0;
      pipe_rst_exmem  = 1'b0;
      pipe_rst_memwb  = 1'b0;
      if (!rst) begin
         pipe_rst_ifid  = 1'b1;
         pipe_rst_idex  = 1'b1;
         pipe_rst_exmem = 1'b1;
         pipe_rst_memwb = 1'b1;
      end else begin
         rs1mux_sel = fwd_sel(idex_rs1);
         rs2mux_sel = fwd_sel(idex_rs2);
         if (advance) begin
            pipe_load_idex  = 1'b1;
            pipe_load_exmem = 1'b1;
            pipe_load_memwb = 1'b1;
            if (br_taken) begin
               pc_load        = 1'b1;
               pipe_load_ifid = 1'b1;
               pipe_rst_ifid  = 1'b1;
               pipe_rst_idex  = 1'b1;
            end else if (lu) begin
               // IF/ID holds; the discarded fetch is reissued since i_got clears.
               pipe_rst_idex = 1'b1;
            end else begin
               pc_load        = 1'b1;
               pipe_load_ifid = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_count <= '0;
      else if (stall_clr)
         stall_count <= '0;
      else if (!advance && stall_count != {CNT_W{1'b1}})
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the control rules.
module tb_hazard_ctrl;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk, rst;
   logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
   logic idex_load_regfile, idex_dcache_read, exmem_load_regfile, exmem_dcache_read;
   logic exmem_dcache_write, memwb_load_regfile, br_taken, icache_resp, dcache_resp, stall_clr;
   logic [1:0] rs1mux_sel, rs2mux_sel;
   logic pc_load, pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb;
   logic pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb;
   logic [CW-1:0] stall_count;

   int n_cmp = 0;
   int n_err = 0;

   // model state: responses already seen for the pending advance, and stall tally
   bit m_i, m_d;
   int m_cnt;

   hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
      .idex_load_regfile(idex_load_regfile), .idex_dcache_read(idex_dcache_read),
      .exmem_rd(exmem_rd), .exmem_load_regfile(exmem_load_regfile),
      .exmem_dcache_read(exmem_dcache_read), .exmem_dcache_write(exmem_dcache_write),
      .memwb_rd(memwb_rd), .memwb_load_regfile(memwb_load_regfile),
      .br_taken(br_taken), .icache_resp(icache_resp), .dcache_resp(dcache_resp),
      .stall_clr(stall_clr),
      .rs1mux_sel(rs1mux_sel), .rs2mux_sel(rs2mux_sel), .pc_load(pc_load),
      .pipe_load_ifid(pipe_load_ifid), .pipe_load_idex(pipe_load_idex),
      .pipe_load_exmem(pipe_load_exmem), .pipe_load_memwb(pipe_load_memwb),
      .pipe_rst_ifid(pipe_rst_ifid), .pipe_rst_idex(pipe_rst_idex),
      .pipe_rst_exmem(pipe_rst_exmem), .pipe_rst_memwb(pipe_rst_memwb),
      .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_fwd(input logic [4:0] rs);
      if (exmem_load_regfile && !exmem_dcache_read && exmem_rd != 0 && exmem_rd == rs) return 1;
      if (memwb_load_regfile && memwb_rd != 0 && memwb_rd == rs) return 2;
      return 0;
   endfunction

   function automatic bit m_adv();
      bit ifetch_ok, data_ok;
      ifetch_ok = icache_resp || m_i;
      data_ok = !(exmem_dcache_read || exmem_dcache_write) || dcache_resp || m_d;
      return ifetch_ok && data_ok;
   endfunction

   // packed as {rs1sel, rs2sel, pc_load, load ifid..memwb, rst ifid..memwb}
   function automatic logic [12:0] m_out();
      bit lu, pc, l_if, l_rest, r_if, r_id;
      if (!rst) return 13'b00_00_0_0000_1111;
      lu = idex_dcache_read && idex_load_regfile && idex_rd != 0 &&
           (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
      pc = 0; l_if = 0; l_rest = 0; r_if = 0; r_id = 0;
      if (m_adv()) begin
         l_rest = 1;
         if (br_taken) begin pc = 1; l_if = 1; r_if = 1; r_id = 1; end
         else if (lu) r_id = 1;
         else begin pc = 1; l_if = 1; end
      end
      return {2'(m_fwd(idex_rs1)), 2'(m_fwd(idex_rs2)), pc, l_if, l_rest, l_rest, l_rest,
              r_if, r_id, 1'b0, 1'b0};
   endfunction

   task automatic tick(input string tag);
      bit adv;
      #1;
      chk(tag, {rs1mux_sel, rs2mux_sel, pc_load, pipe_load_ifid, pipe_load_idex,
                pipe_load_exmem, pipe_load_memwb, pipe_rst_ifid, pipe_rst_idex,
                pipe_rst_exmem, pipe_rst_memwb}, m_out());
      adv = m_adv();
      @(posedge clk);
      if (!rst) begin
         m_i = 0; m_d = 0; m_cnt = 0;
      end else begin
         if (adv) begin m_i = 0; m_d = 0; end
         else begin m_i = m_i | icache_resp; m_d = m_d | dcache_resp; end
         if (stall_clr) m_cnt = 0;
         else if (!adv && m_cnt < CMAX) m_cnt++;
      end
      @(negedge clk);
      chk({tag, ".cnt"}, stall_count, m_cnt);
   endtask

   task automatic set_idle();
      rst = 1; ifid_rs1 = 0; ifid_rs2 = 0; idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0;
      idex_load_regfile = 0; idex_dcache_read = 0; exmem_rd = 0; exmem_load_regfile = 0;
      exmem_dcache_read = 0; exmem_dcache_write = 0; memwb_rd = 0; memwb_load_regfile = 0;
      br_taken = 0; icache_resp = 0; dcache_resp = 0; stall_clr = 0;
   endtask

   initial begin
      set_idle();
      m_i = 0; m_d = 0; m_cnt = 0;
      rst = 0;
      @(negedge clk);

      // reset held with fetch responses present
      icache_resp = 1;
      for (int i = 0; i < 3; i++) begin
         tick("reset");
         chk("reset.rst_memwb", pipe_rst_memwb, 1);
      end
      rst = 1;
      tick("release");

      // forwarding priority and x0
      idex_rs1 = 5; exmem_rd = 5; exmem_load_regfile = 1; memwb_rd = 5; memwb_load_regfile = 1;
      #1 chk("fwd.exmem", rs1mux_sel, 1);
      tick("fwd.exmem");
      exmem_rd = 0;
      #1 chk("fwd.memwb", rs1mux_sel, 2);
      tick("fwd.memwb");
      idex_rs2 = 0;
      #1 chk("fwd.x0", rs2mux_sel, 0);
      tick("fwd.x0");
      exmem_rd = 5; exmem_dcache_read = 1;
      tick("fwd.load_in_mem");
      set_idle();

      // load-use: one bubble then normal advance
      icache_resp = 1; idex_dcache_read = 1; idex_load_regfile = 1; idex_rd = 7; ifid_rs2 = 7;
      #1 chk("lu.rst_idex", pipe_rst_idex, 1);
      tick("lu.bubble");
      idex_dcache_read = 0; idex_load_regfile = 0; idex_rd = 0;
      tick("lu.after");

      // split responses: D at cycle 2, I at cycle 5
      set_idle();
      exmem_dcache_read = 1; exmem_rd = 3; exmem_load_regfile = 1;
      for (int c = 1; c <= 5; c++) begin
         icache_resp = (c == 5); dcache_resp = (c == 2);
         tick("split");
      end
      set_idle();

      // branch beats load-use
      icache_resp = 1; br_taken = 1;
      idex_dcache_read = 1; idex_load_regfile = 1; idex_rd = 9; ifid_rs1 = 9;
      #1 chk("br.pc_load", pc_load, 1);
      tick("br_vs_lu");
      set_idle();

      // saturation, then clear mid-stall
      for (int i = 0; i < 20; i++) tick("sat");
      chk("sat.max", stall_count, CMAX);
      stall_clr = 1;
      tick("clr");
      stall_clr = 0;
      tick("post_clr");

      // randomized traffic including mid-stall resets
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 59) != 0);
         ifid_rs1 = 5'($urandom_range(0, 3)); ifid_rs2 = 5'($urandom_range(0, 3));
         idex_rs1 = 5'($urandom_range(0, 3)); idex_rs2 = 5'($urandom_range(0, 3));
         idex_rd = 5'($urandom_range(0, 3)); exmem_rd = 5'($urandom_range(0, 3));
         memwb_rd = 5'($urandom_range(0, 3));
         idex_load_regfile = 1'($urandom); idex_dcache_read = 1'($urandom);
         exmem_load_regfile = 1'($urandom); memwb_load_regfile = 1'($urandom);
         exmem_dcache_read = ($urandom_range(0, 3) == 0);
         exmem_dcache_write = ($urandom_range(0, 3) == 0);
         br_taken = ($urandom_range(0, 4) == 0);
         icache_resp = ($urandom_range(0, 2) == 0);
         dcache_resp = ($urandom_range(0, 2) == 0);
         stall_clr = ($urandom_range(0, 39) == 0);
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
